// File: rtl/seq_bit_serializer_pkg.sv
// seq_bit_serializer_pkg: shared state encoding and default parameters for the serializer
package seq_bit_serializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 8;
  localparam bit DEF_IDLE_BIT = 1'b0;
endpackage

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial feeder with a one-word holding register for gapless streaming
module seq_bit_serializer
  import seq_bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);
  localparam int KW = $clog2(WIDTH);
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [WIDTH-1:0] shreg, hold;
  logic hold_full, acc, last;
  assign load_ready = ~hold_full & ~rst;
  assign acc = load_valid & load_ready;
  assign last = (state == SHIFT) && (k == KW'(WIDTH-1));
  always_comb begin
    state_n = (state == IDLE) ? (acc ? SHIFT : IDLE) : ((last & ~hold_full & ~acc) ? IDLE : SHIFT);
    x_valid = (state == SHIFT);
    x_out = x_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;
    frame_start = x_valid && (k == '0);
    frame_done = last;
    busy = x_valid | hold_full;
  end
  // A word ending with the holding register empty can be replaced at the same edge, so no gap bit appears
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      shreg <= '0;
      hold <= '0;
      hold_full <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE || last) begin
        k <= '0;
        if (last && hold_full) begin
          shreg <= hold;
          hold_full <= 1'b0;
        end else if (acc) shreg <= load_data;
      end else begin
        k <= k + 1'b1;
        shreg <= MSB_FIRST ? shreg << 1 : shreg >> 1;
        if (acc) begin
          hold <= load_data;
          hold_full <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: MSB-first and LSB-first instances checked against a bit-queue reference model
module tb_seq_bit_serializer;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic rdy_m, x_m, v_m, fs_m, fd_m, b_m;
  logic rdy_l, x_l, v_l, fs_l, fd_l, b_l;
  int n_cmp = 0, n_err = 0;
  int qm[$], ql[$];
  logic acc, acc_dut;
  logic [31:0] cap_m, cap_l;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid), .load_ready(rdy_m),
    .x_out(x_m), .x_valid(v_m), .frame_start(fs_m), .frame_done(fd_m), .busy(b_m)
  );
  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid), .load_ready(rdy_l),
    .x_out(x_l), .x_valid(v_l), .frame_start(fs_l), .frame_done(fd_l), .busy(b_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each queued entry is one pending output bit: bit value in [0], index within its word above it
  function automatic void push(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      qm.push_back(int'(w[W-1-i]) | (i << 1));
      ql.push_back(int'(w[i]) | (i << 1));
    end
  endfunction

  task automatic chk_dut(input string n, input int sz, input int f,
                         input logic x, input logic v, input logic fs, input logic fd, input logic b);
    chk({n, ".x_valid"}, v, sz > 0);
    chk({n, ".x_out"}, x, sz > 0 ? f[0] : 1'b0);
    chk({n, ".frame_start"}, fs, sz > 0 && (f >> 1) == 0);
    chk({n, ".frame_done"}, fd, sz > 0 && (f >> 1) == W - 1);
    chk({n, ".busy"}, b, sz > 0);
  endtask

  task automatic tick();
    #1;
    acc = load_valid && !rst && qm.size() <= W;
    acc_dut = load_valid && rdy_m;
    chk("msb.load_ready", rdy_m, !rst && qm.size() <= W);
    chk("lsb.load_ready", rdy_l, !rst && ql.size() <= W);
    @(posedge clk);
    if (rst) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) push(load_data);
    end
    #1;
    chk_dut("msb", qm.size(), qm.size() > 0 ? qm[0] : 0, x_m, v_m, fs_m, fd_m, b_m);
    chk_dut("lsb", ql.size(), ql.size() > 0 ? ql[0] : 0, x_l, v_l, fs_l, fd_l, b_l);
    if (v_m === 1'b1) cap_m = {cap_m[30:0], x_m};
    if (v_l === 1'b1) cap_l = {cap_l[30:0], x_l};
  endtask

  task automatic send(input logic [W-1:0] w);
    load_data = w;
    load_valid = 1'b1;
    acc_dut = 1'b0;
    for (int i = 0; i < 40 && !acc_dut; i++) tick();
    chk("send_accepted", acc_dut, 1'b1);
  endtask

  task automatic idle(input int n);
    load_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    cap_m = '0;
    cap_l = '0;
    rst = 1'b1;
    load_valid = 1'b1;
    load_data = 8'hAA;
    repeat (3) tick();
    rst = 1'b0;
    idle(2);
    chkv("reset_no_bits", cap_m, 32'h0);
    send(8'hB4);
    idle(9);
    chkv("single_msb", cap_m, 32'h0000_00B4);
    chkv("single_lsb", cap_l, 32'h0000_002D);
    cap_m = '0;
    cap_l = '0;
    send(8'hB4);
    send(8'h0F);
    idle(17);
    chkv("b2b_msb", cap_m, 32'h0000_B40F);
    chkv("b2b_lsb", cap_l, 32'h0000_2DF0);
    cap_m = '0;
    cap_l = '0;
    send(8'h5A);
    send(8'hA5);
    idle(17);
    chkv("pattern_msb", cap_m, 32'h0000_5AA5);
    chkv("pattern_lsb", cap_l, 32'h0000_5AA5);
    cap_m = '0;
    cap_l = '0;
    send(8'hFF);
    send(8'h00);
    load_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(12);
    chkv("rst_mid_msb", cap_m, 32'h0000_000F);
    chkv("rst_mid_lsb", cap_l, 32'h0000_000F);
    repeat (400) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data = W'($urandom);
      rst = ($urandom_range(0, 60) == 0);
      tick();
    end
    rst = 1'b0;
    idle(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
